// File: rtl/io_arbiter_pkg.sv
// Shared types and constants for the two-requester IO arbiter.
package io_arbiter_pkg;

  localparam int NUM_REQ                 = 2;
  localparam int DEFAULT_MAX_OUTSTANDING = 4;
  localparam int DATA_W                  = 32;

  // Requester identifier carried through the read-tag FIFO.
  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/io_arbiter_tag_fifo.sv
// In-order FIFO of requester IDs for device reads in flight.
// A read return always belongs to the oldest outstanding read.
module io_arbiter_tag_fifo
  import io_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MAX_OUTSTANDING,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  req_id_t       id_i,
  output req_id_t       id_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  req_id_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign id_o    = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= id_i;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing one IO device between two requesters.
// Reads are tagged in an in-order FIFO so returns are routed back to
// the requester that issued them.
module io_arbiter
  import io_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0Read,
  input  logic              m0Write,
  input  logic [DATA_W-1:0] m0DataIn,
  output logic              m0WaitRequest,
  output logic              m0ReadValid,
  output logic [DATA_W-1:0] m0DataOut,
  input  logic              m1Read,
  input  logic              m1Write,
  input  logic [DATA_W-1:0] m1DataIn,
  output logic              m1WaitRequest,
  output logic              m1ReadValid,
  output logic [DATA_W-1:0] m1DataOut,
  output logic              devRead,
  output logic              devWrite,
  output logic [DATA_W-1:0] devDataIn,
  input  logic              devReadValid,
  input  logic [DATA_W-1:0] devDataOut,
  output logic              error
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [NUM_REQ-1:0] req, rd, elig, gnt;
  logic               gnt_rd;
  logic [DATA_W-1:0]  gnt_data;

  // Last granted requester; reset to m1 so m0 wins the first contention.
  logic last_q;

  logic              dev_rd_q, dev_rd_d, dev_wr_q, dev_wr_d;
  logic [DATA_W-1:0] dev_din_q, dev_din_d;

  logic [NUM_REQ-1:0]             rv_q, rv_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] dout_q, dout_d;
  logic                           err_q, err_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, orphan;
  req_id_t       fifo_tag;
  logic [CW-1:0] fifo_cnt;

  io_arbiter_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk    (clk),
    .rst    (reset),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .id_i   (req_id_t'(gnt[1])),
    .id_o   (fifo_tag),
    .count_o(fifo_cnt),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Arbitration: a read (which wins over a simultaneous write) is not
  // eligible while the tag FIFO is full, regardless of a same-cycle pop.
  always_comb begin
    req  = {m1Read | m1Write, m0Read | m0Write};
    rd   = {m1Read, m0Read};
    elig = req & ~(rd & {NUM_REQ{fifo_full}}) & {NUM_REQ{~reset}};
    gnt  = elig;
    if (&elig) gnt = last_q ? 2'b01 : 2'b10;
    gnt_rd   = |(gnt & rd);
    gnt_data = gnt[1] ? m1DataIn : m0DataIn;
  end

  assign m0WaitRequest = req[0] & ~gnt[0];
  assign m1WaitRequest = req[1] & ~gnt[1];

  // Tag FIFO control; a return with nothing outstanding is an orphan.
  always_comb begin
    fifo_push = gnt_rd;
    fifo_pop  = devReadValid & ~fifo_empty;
    orphan    = devReadValid & (fifo_cnt == '0);
  end

  // Next-state for device strobes, return strobes and sticky error.
  always_comb begin
    dev_rd_d  = gnt_rd;
    dev_wr_d  = (|gnt) & ~gnt_rd;
    dev_din_d = (|gnt) ? gnt_data : dev_din_q;
    rv_d      = '0;
    dout_d    = dout_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      rv_d[i] = fifo_pop & (fifo_tag == req_id_t'(i));
      if (rv_d[i]) dout_d[i] = devDataOut;
    end
    err_d = err_q | orphan;
  end

  // Output and round-robin registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= 1'b1;
      dev_rd_q  <= 1'b0;
      dev_wr_q  <= 1'b0;
      dev_din_q <= '0;
      rv_q      <= '0;
      dout_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (|gnt) last_q <= gnt[1];
      dev_rd_q  <= dev_rd_d;
      dev_wr_q  <= dev_wr_d;
      dev_din_q <= dev_din_d;
      rv_q      <= rv_d;
      dout_q    <= dout_d;
      err_q     <= err_d;
    end
  end

  assign devRead     = dev_rd_q;
  assign devWrite    = dev_wr_q;
  assign devDataIn   = dev_din_q;
  assign m0ReadValid = rv_q[0];
  assign m1ReadValid = rv_q[1];
  assign m0DataOut   = dout_q[0];
  assign m1DataOut   = dout_q[1];
  assign error       = err_q;

endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 4, maximum device reads in flight (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m0Read, m1Read  input  1 each  requester read request; held until accepted.
REQ-005 m0Write, m1Write  input  1 each  requester write request; held until accepted.
REQ-006 m0DataIn, m1DataIn  input  32 each  requester write data.
REQ-007 m0WaitRequest, m1WaitRequest  output  1 each  request not accepted this cycle.
REQ-008 m0ReadValid, m1ReadValid  output  1 each  one-cycle read-return strobe.
REQ-009 m0DataOut, m1DataOut  output  32 each  read-return data.
REQ-010 devRead, devWrite  output  1 each  registered strobes to the shared IO device.
REQ-011 devDataIn  output  32  registered write data to device.
REQ-012 devReadValid  input  1  device read-return strobe.
REQ-013 devDataOut  input  32  device read data.
REQ-014 error  output  1  sticky: devReadValid received with no read outstanding.

Function
REQ-015 Requester i requests when mIRead or mIWrite is high; at most one requester is granted per cycle.
REQ-016 Arbitration SHALL be round-robin: on contention, grant the requester not granted most recently; single requester granted immediately.
REQ-017 mIWaitRequest SHALL be combinational: high when requester i requests and is not granted this cycle; low otherwise.
REQ-018 Read grant is blocked while outstanding count == MAX_OUTSTANDING, even if a pop occurs the same cycle; blocked read does not update the round-robin pointer and the other requester may be granted.
REQ-019 Writes are never blocked by the outstanding count.
REQ-020 Requester asserting read and write together SHALL be served as a read only; the write is discarded.
REQ-021 Grant in cycle N: devRead/devWrite high for exactly cycle N+1, devDataIn = granted mIDataIn sampled at N; otherwise devRead = devWrite = 0 and devDataIn holds.
REQ-022 Each read grant pushes the requester ID into an in-order tag FIFO; each devReadValid pops it.
REQ-023 devReadValid in cycle M: mXReadValid high for cycle M+1 only (X = popped tag), mXDataOut = devDataOut sampled at M; other requester's DataOut holds.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged and both take effect.
REQ-025 devReadValid with empty FIFO: no requester strobe, count stays 0, error set until reset.
REQ-026 Count and FIFO pointers wrap modulo MAX_OUTSTANDING without loss of order.

Reset
REQ-027 Reset SHALL clear devRead, devWrite, devDataIn, m0/m1ReadValid, m0/m1DataOut, error, FIFO count/pointers; round-robin pointer set so m0 wins first contention.
REQ-028 While reset is high no grants occur (WaitRequest = request); reset mid-operation discards all outstanding reads, and later devReadValid with empty FIFO sets error after reset releases.

Structure
REQ-029 Shared package io_arbiter_pkg SHALL hold the requester-ID typedef, requester count (2), and default MAX_OUTSTANDING.
REQ-030 Tag FIFO SHALL be a sub-module io_arbiter_tag_fifo (push, pop, id in/out, count, full, empty; async active-high reset).

Verification
REQ-031 Reset, m0Write=1, m0DataIn=0x000000A5 one cycle -> m0WaitRequest=0, devWrite=1 and devDataIn=0x000000A5 next cycle.
REQ-032 m0Read and m1Read held together from reset -> grants m0, m1, m0...; each WaitRequest low once per two cycles.
REQ-033 m1 read granted, device returns 0x3C two cycles after devRead -> m1ReadValid one cycle after devReadValid, m1DataOut=0x3C, m0ReadValid stays 0.
REQ-034 Device withholds devReadValid, m0 issues 5 reads -> 4 accepted, fifth waits; m1Write meanwhile accepted; first devReadValid -> fifth read accepted on a following cycle.
REQ-035 devReadValid pulse with nothing outstanding -> error=1 and stays high until reset; no ReadValid strobe.
REQ-036 Reset asserted with 2 reads outstanding -> all outputs zero, count 0; post-reset devReadValid sets error.
